// File: rtl/add_card_if.sv
// Operand/result bundle for the 8-bit add_card ALU.
// No valid/ready: the card accepts a new operation every cycle, res follows the operands combinationally, flags lag by one clock.
interface add_card_if;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       csel;
  logic       cclear;
  logic [7:0] res;
  logic       sign_reg;
  logic       z_reg;

  modport master (
    output a, b, op, csel, cclear,
    input  res, sign_reg, z_reg
  );

  modport slave (
    input  a, b, op, csel, cclear,
    output res, sign_reg, z_reg
  );
endinterface

// File: rtl/add_card.sv
// Eight-bit arithmetic/logic card: combinational result, registered sign/zero/carry status.
module add_card (
  input  logic      clk,
  input  logic      rst_n,
  add_card_if.slave bus
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_ADC = 3'd4,
    OP_SBC = 3'd5,
    OP_LSL = 3'd6,
    OP_LSR = 3'd7
  } op_e;

  op_e        w_op;
  logic       w_cin;
  logic [8:0] w_sum;
  logic [7:0] w_res;
  logic       w_arith;

  logic       r_carry;
  logic       r_sign;
  logic       r_zero;

  assign w_op = op_e'(bus.op);

  // cclear dominates csel; with neither, chained ops pick up the stored carry.
  always_comb begin
    w_cin = r_carry;
    if (bus.cclear)
      w_cin = 1'b0;
    else if (bus.csel)
      w_cin = 1'b1;
  end

  always_comb begin
    w_sum   = 9'd0;
    w_res   = 8'd0;
    w_arith = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
        w_res   = w_sum[7:0];
        w_arith = 1'b1;
      end
      OP_SUB: begin
        w_sum   = {1'b0, bus.a} + {1'b0, ~bus.b} + 9'd1;
        w_res   = w_sum[7:0];
        w_arith = 1'b1;
      end
      OP_AND: w_res = bus.a & bus.b;
      OP_OR:  w_res = bus.a | bus.b;
      OP_ADC: begin
        w_sum   = {1'b0, bus.a} + {1'b0, bus.b} + {8'd0, w_cin};
        w_res   = w_sum[7:0];
        w_arith = 1'b1;
      end
      OP_SBC: begin
        w_sum   = {1'b0, bus.a} + {1'b0, ~bus.b} + {8'd0, w_cin};
        w_res   = w_sum[7:0];
        w_arith = 1'b1;
      end
      OP_LSL: w_res = bus.a << bus.b[2:0];
      OP_LSR: w_res = bus.a >> bus.b[2:0];
      default: w_res = 8'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
      r_sign  <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_sign <= w_res[7];
      r_zero <= (w_res == 8'd0);
      if (w_arith)
        r_carry <= w_sum[8];
    end
  end

  assign bus.res      = w_res;
  assign bus.sign_reg = r_sign;
  assign bus.z_reg    = r_zero;

endmodule

// File: tb/tb_add_card.sv
// Directed-vector bench for add_card; stored carry is read back through an op4 a=0,b=0 probe.
module tb_add_card;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  add_card_if bus ();

  add_card dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic csel, input logic cclear);
    bus.op     = op;
    bus.a      = a;
    bus.b      = b;
    bus.csel   = csel;
    bus.cclear = cclear;
  endtask

  // Apply on the falling edge, check res before the next rising edge.
  task automatic alu(input string tag, input logic [2:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic csel, input logic cclear,
                     input logic [7:0] exp_res);
    @(negedge clk);
    drive(op, a, b, csel, cclear);
    #1;
    check(tag, bus.res, exp_res);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input string tag, input logic exp_sign, input logic exp_z);
    check({tag, "_sign"}, {7'd0, bus.sign_reg}, {7'd0, exp_sign});
    check({tag, "_z"},    {7'd0, bus.z_reg},    {7'd0, exp_z});
  endtask

  // Only between edges: op4 0+0+carry exposes the stored carry without clocking it.
  task automatic probe_carry(input string tag, input logic exp_c);
    drive(3'd4, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    check({tag, "_carry"}, bus.res, {7'd0, exp_c});
  endtask

  initial begin
    rst_n = 1'b0;
    drive(3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    #2;
    flags("reset", 1'b0, 1'b0);
    probe_carry("reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic ALU, a=5 b=-3
    alu("add", 3'd0, 8'h05, 8'hFD, 1'b0, 1'b0, 8'h02);
    tick(); flags("add", 1'b0, 1'b0); probe_carry("add", 1'b1);
    alu("sub", 3'd1, 8'h05, 8'hFD, 1'b0, 1'b0, 8'h08);
    tick(); probe_carry("sub", 1'b0);
    alu("and", 3'd2, 8'h05, 8'hFD, 1'b0, 1'b0, 8'h05);
    tick(); probe_carry("and", 1'b0);
    alu("or", 3'd3, 8'h05, 8'hFD, 1'b0, 1'b0, 8'hFD);
    tick(); flags("or", 1'b1, 1'b0);

    // ADC carry-in selection
    alu("adc_clr", 3'd4, 8'h05, 8'hFD, 1'b0, 1'b1, 8'h02);
    tick(); probe_carry("adc_clr", 1'b1);
    alu("adc_clr_sel", 3'd4, 8'h05, 8'hFD, 1'b1, 1'b1, 8'h02);
    tick();
    alu("adc_sel", 3'd4, 8'h05, 8'hFD, 1'b1, 1'b0, 8'h03);
    tick();
    alu("adc_stored", 3'd4, 8'h05, 8'hFD, 1'b0, 1'b0, 8'h03);
    tick(); probe_carry("adc_stored", 1'b1);

    // SBC carry-in selection
    alu("sbc_clr", 3'd5, 8'h05, 8'hFD, 1'b0, 1'b1, 8'h07);
    tick(); probe_carry("sbc_clr", 1'b0);
    alu("sbc_sel", 3'd5, 8'h05, 8'hFD, 1'b1, 1'b0, 8'h08);
    tick();
    alu("sbc_stored0", 3'd5, 8'h05, 8'hFD, 1'b0, 1'b0, 8'h07);
    tick();

    // Compare
    alu("cmp_eq", 3'd5, 8'h05, 8'h05, 1'b1, 1'b0, 8'h00);
    tick(); flags("cmp_eq", 1'b0, 1'b1); probe_carry("cmp_eq", 1'b1);
    alu("cmp_gt", 3'd5, 8'h05, 8'h04, 1'b1, 1'b0, 8'h01);
    tick(); flags("cmp_gt", 1'b0, 1'b0); probe_carry("cmp_gt", 1'b1);
    alu("sbc_stored1", 3'd5, 8'h05, 8'hFD, 1'b0, 1'b0, 8'h08);
    tick();
    alu("cmp_lt", 3'd5, 8'h04, 8'h05, 1'b1, 1'b0, 8'hFF);
    tick(); flags("cmp_lt", 1'b1, 1'b0); probe_carry("cmp_lt", 1'b0);

    // Shifts, with carry set beforehand so holding is visible
    alu("add_pre", 3'd0, 8'h05, 8'hFD, 1'b0, 1'b0, 8'h02);
    tick();
    alu("lsl_2_0", 3'd6, 8'h02, 8'h00, 1'b0, 1'b1, 8'h02);
    tick();
    alu("lsl_2_1", 3'd6, 8'h02, 8'h01, 1'b1, 1'b0, 8'h04);
    tick();
    alu("lsl_1_1", 3'd6, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02);
    tick();
    alu("lsl_ff_9", 3'd6, 8'hFF, 8'h09, 1'b0, 1'b0, 8'hFE);
    tick(); flags("lsl_ff", 1'b1, 1'b0);
    alu("lsl_0_2", 3'd6, 8'h00, 8'h02, 1'b0, 1'b0, 8'h00);
    tick(); flags("lsl_0", 1'b0, 1'b1);
    alu("lsr_1_2", 3'd7, 8'h01, 8'h02, 1'b0, 1'b0, 8'h00);
    tick();
    alu("lsr_80_7", 3'd7, 8'h80, 8'h07, 1'b0, 1'b0, 8'h01);
    tick(); flags("lsr_80", 1'b0, 1'b0); probe_carry("shifts", 1'b1);

    // Asynchronous reset with sign and carry set
    alu("or_pre", 3'd3, 8'h80, 8'h00, 1'b0, 1'b0, 8'h80);
    tick(); flags("pre_rst", 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    flags("async_rst", 1'b0, 1'b0);
    probe_carry("async_rst", 1'b0);
    alu("in_rst", 3'd0, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00);
    tick(); flags("held_rst", 1'b0, 1'b0); probe_carry("held_rst", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    alu("post_rst_adc", 3'd4, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02);
    tick(); flags("post_rst", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
